// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-port main memory between the multicycle CPU and a
// DMA/display requester. Each requester's request is captured into its own
// command register and a pending bit is set. Whenever the arbiter is idle, one
// pending requester is granted. The memory is then strobed for MEM_LAT cycles.
// A one-cycle ok pulse follows, and on reads it comes with registered read data.
//
// Configuration macro: CPU_PRIORITY_EN
//   undefined : round-robin between CPU and DMA on a tie (default build)
//   defined   : CPU always wins a tie; DMA may be starved
//
// Parameters:
//   AW      address width
//   DW      data width
//   MEM_LAT cycles mem_en is held per access (1..15)
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cpu_req/we/half/addr/wdata  CPU command inputs
//   cpu_ok, cpu_rdata           CPU completion pulse and read data
//   dma_req/we/addr/wdata       DMA command inputs (DMA is always word access)
//   dma_ok, dma_rdata           DMA completion pulse and read data
//   mem_en/we/half/addr/wdata   memory strobe and command
//   mem_rdata                   memory read data, valid on last mem_en cycle
//   grant                       current owner: 0=CPU, 1=DMA
//   busy                        high while an access is in ACCESS or DONE
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_half,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ok,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ok,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_half,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic          half;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       grant_q, grant_nxt;
`ifndef CPU_PRIORITY_EN
    logic       last_grant, last_nxt;
`endif
    logic [1:0] pending;
    cmd_t       cpu_cmd, dma_cmd, sel_cmd;
    logic       finish;

    // The last ACCESS cycle: pending of the owner clears here and its ok
    // rises on this same edge.
    assign finish  = (state == ACCESS) && (cnt == 4'd0);
    assign sel_cmd = grant_q ? dma_cmd : cpu_cmd;

    // State register: FSM state, latency counter, owner and tie-break history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            grant_q    <= 1'b0;
`ifndef CPU_PRIORITY_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            grant_q    <= grant_nxt;
`ifndef CPU_PRIORITY_EN
            last_grant <= last_nxt;
`endif
        end
    end

    // Next-state logic: arbitration in IDLE, latency countdown in ACCESS.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
`ifndef CPU_PRIORITY_EN
        last_nxt  = last_grant;
`endif
        case (state)
            IDLE: begin
                if (pending != 2'b00) begin
                    if (pending == 2'b11) begin
`ifdef CPU_PRIORITY_EN
                        grant_nxt = 1'b0;
`else
                        grant_nxt = ~last_grant;
`endif
                    end else begin
                        grant_nxt = pending[1];
                    end
                    cnt_nxt   = CNT_INIT;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
`ifndef CPU_PRIORITY_EN
                    last_nxt = grant_q;
`endif
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state register alone. An async reset
    // therefore drops mem_en and ok at once, and the memory bus sits at zero
    // outside ACCESS.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_half  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ok    = 1'b0;
        dma_ok    = 1'b0;
        if (state == ACCESS) begin
            mem_en    = 1'b1;
            mem_we    = sel_cmd.we;
            mem_half  = sel_cmd.half;
            mem_addr  = sel_cmd.addr;
            mem_wdata = sel_cmd.wdata;
        end
        if (state == DONE) begin
            cpu_ok = ~grant_q;
            dma_ok = grant_q;
        end
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

    // Request capture and read-data return. The finishing owner's pending bit
    // is freed on the edge that raises its ok. A request in that same cycle
    // is therefore accepted as a new command, even though the command
    // register is still selected during this final ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= 2'b00;
            cpu_cmd   <= '0;
            dma_cmd   <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            if (finish) begin
                pending[grant_q] <= 1'b0;
                if (!sel_cmd.we) begin
                    if (grant_q) dma_rdata <= mem_rdata;
                    else         cpu_rdata <= mem_rdata;
                end
            end
            if (cpu_req && (!pending[0] || (finish && !grant_q))) begin
                pending[0] <= 1'b1;
                cpu_cmd    <= '{we: cpu_we, half: cpu_half, addr: cpu_addr, wdata: cpu_wdata};
            end
            if (dma_req && (!pending[1] || (finish && grant_q))) begin
                pending[1] <= 1'b1;
                dma_cmd    <= '{we: dma_we, half: 1'b0, addr: dma_addr, wdata: dma_wdata};
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. A transaction-level model tracks
// pending commands and the time since each grant, and it predicts every
// output. A compare process checks the DUT against the model on each falling
// edge. Literal expectations from hand calculation are checked at key
// points. The memory is a combinational function of mem_addr.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req, cpu_we, cpu_half;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ok;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ok;
    logic [DW-1:0] dma_rdata;
    logic          mem_en, mem_we, mem_half;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          grant, busy;

    int vectors = 0;
    int miscompares = 0;
    bit cmpEn = 1'b0;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_half(cpu_half),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ok(cpu_ok), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ok(dma_ok), .dma_rdata(dma_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_half(mem_half),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory contents: one fixed word at 0x40, otherwise derived from the address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = memfn(mem_addr);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model. mTime is the number of edges since the grant:
    // -1 means idle, 0..LAT-1 means the memory is strobed, and LAT is the ok cycle.
    bit          mPend [2];
    logic        mWe   [2];
    logic        mHalf [2];
    logic [31:0] mAddr [2];
    logic [31:0] mWd   [2];
    logic [31:0] mRd   [2];
    int          mTime;
    int          mOwner;
    int          mLast;
    int          prevOwner;
    bit          fin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 2; r++) begin
                mPend[r] = 1'b0; mWe[r] = 1'b0; mHalf[r] = 1'b0;
                mAddr[r] = '0;   mWd[r] = '0;   mRd[r] = '0;
            end
            mTime = -1; mOwner = 0; mLast = 1;
        end else begin
            fin = (mTime == LAT - 1);
            prevOwner = mOwner;
            if (mTime < 0) begin
                if (mPend[0] || mPend[1]) begin
                    if (mPend[0] && mPend[1]) begin
`ifdef CPU_PRIORITY_EN
                        mOwner = 0;
`else
                        mOwner = (mLast == 0) ? 1 : 0;
`endif
                    end else begin
                        mOwner = mPend[0] ? 0 : 1;
                    end
                    mTime = 0;
                end
            end else if (mTime < LAT) begin
                mTime++;
            end else begin
                mTime = -1;
            end
            if (fin) begin
                if (!mWe[prevOwner]) mRd[prevOwner] = memfn(mAddr[prevOwner]);
                mPend[prevOwner] = 1'b0;
                mLast = prevOwner;
            end
            if (cpu_req && !mPend[0]) begin
                mPend[0] = 1'b1; mWe[0] = cpu_we; mHalf[0] = cpu_half;
                mAddr[0] = cpu_addr; mWd[0] = cpu_wdata;
            end
            if (dma_req && !mPend[1]) begin
                mPend[1] = 1'b1; mWe[1] = dma_we; mHalf[1] = 1'b0;
                mAddr[1] = dma_addr; mWd[1] = dma_wdata;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (cmpEn && rst_n) begin
            checkOutput("mem_en",    mem_en,    (mTime >= 0 && mTime < LAT));
            checkOutput("mem_we",    mem_we,    (mTime >= 0 && mTime < LAT) ? mWe[mOwner] : 1'b0);
            checkOutput("mem_half",  mem_half,  (mTime >= 0 && mTime < LAT) ? mHalf[mOwner] : 1'b0);
            checkOutput("mem_addr",  mem_addr,  (mTime >= 0 && mTime < LAT) ? mAddr[mOwner] : 32'h0);
            checkOutput("mem_wdata", mem_wdata, (mTime >= 0 && mTime < LAT) ? mWd[mOwner] : 32'h0);
            checkOutput("cpu_ok",    cpu_ok,    (mTime == LAT && mOwner == 0));
            checkOutput("dma_ok",    dma_ok,    (mTime == LAT && mOwner == 1));
            checkOutput("cpu_rdata", cpu_rdata, mRd[0]);
            checkOutput("dma_rdata", dma_rdata, mRd[1]);
            checkOutput("grant",     grant,     mOwner[0]);
            checkOutput("busy",      busy,      (mTime >= 0));
        end
    end

    // Drive one cycle of requests, sampled on the next rising edge, then drop the reqs.
    task automatic applyStimulus(input bit creq, input bit cwe, input bit chalf,
                                 input logic [31:0] caddr, input logic [31:0] cwd,
                                 input bit dreq, input bit dwe,
                                 input logic [31:0] daddr, input logic [31:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_half = chalf; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        @(negedge clk);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cpu_req = 0; cpu_we = 0; cpu_half = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_en",    mem_en,    1'b0);
        checkOutput("rst_busy",      busy,      1'b0);
        checkOutput("rst_grant",     grant,     1'b0);
        checkOutput("rst_cpu_ok",    cpu_ok,    1'b0);
        checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
        rst_n = 1'b1;
        cmpEn = 1'b1;
        waitCycles(1);

        // Tie right after reset: CPU first, DMA after one IDLE bubble.
        applyStimulus(1, 0, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        waitCycles(1);
        checkOutput("tie1_grant_cpu", grant,    1'b0);
        checkOutput("tie1_addr_cpu",  mem_addr, 32'h10);
        waitCycles(4);
        checkOutput("tie1_grant_dma", grant,    1'b1);
        checkOutput("tie1_addr_dma",  mem_addr, 32'h20);
        waitCycles(4);

        // Lone CPU read of 0x40.
        applyStimulus(1, 0, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0);
        waitCycles(1);
        checkOutput("rd_mem_en",   mem_en,   1'b1);
        checkOutput("rd_mem_addr", mem_addr, 32'h40);
        waitCycles(2);
        checkOutput("rd_cpu_ok",    cpu_ok,    1'b1);
        checkOutput("rd_dma_ok",    dma_ok,    1'b0);
        checkOutput("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        waitCycles(2);

        // Tie after a CPU access: round-robin picks DMA first.
        applyStimulus(1, 0, 0, 32'h30, 32'h0, 1, 0, 32'h24, 32'h0);
        waitCycles(1);
`ifdef CPU_PRIORITY_EN
        checkOutput("tie2_grant", grant, 1'b0);
`else
        checkOutput("tie2_grant", grant, 1'b1);
`endif
        waitCycles(9);

        // DMA write, with CPU requests arriving while the DMA access is in progress.
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 1, 1, 32'h100, 32'h12345678);
        waitCycles(1);
        checkOutput("wr_mem_we",    mem_we,    1'b1);
        checkOutput("wr_mem_wdata", mem_wdata, 32'h12345678);
        applyStimulus(1, 0, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("wr_mem_we2",   mem_we,    1'b1);
        applyStimulus(1, 0, 0, 32'hC, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("wr_dma_ok",    dma_ok,    1'b1);
        checkOutput("wr_dma_rdata", dma_rdata, 32'h0024FFDB);
        waitCycles(2);
        checkOutput("held_grant", grant,    1'b0);
        checkOutput("held_addr",  mem_addr, 32'h8);
        waitCycles(4);

        // CPU halfword store.
        applyStimulus(1, 1, 1, 32'h200, 32'hABCD, 0, 0, 32'h0, 32'h0);
        waitCycles(1);
        checkOutput("hw_half1", mem_half, 1'b1);
        checkOutput("hw_we",    mem_we,   1'b1);
        waitCycles(1);
        checkOutput("hw_half2", mem_half, 1'b1);
        waitCycles(2);
        checkOutput("hw_half_idle", mem_half, 1'b0);
        checkOutput("hw_busy_idle", busy,     1'b0);
        waitCycles(1);

        // Reset asserted in the second ACCESS cycle.
        applyStimulus(1, 0, 0, 32'h300, 32'h0, 0, 0, 32'h0, 32'h0);
        waitCycles(2);
        checkOutput("mid_mem_en_pre", mem_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_mem_en", mem_en, 1'b0);
        checkOutput("mid_busy",   busy,   1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_ok", cpu_ok, 1'b0);
            checkOutput("post_rst_idle",  mem_en, 1'b0);
        end

        cmpEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port main memory between the multicycle CPU (control unit fetch/load/store path) and a DMA/display requester.
- Captures each request into a per-requester command register.
- Grants one requester at a time (round-robin), runs a fixed-latency memory access, and returns a one-cycle ok pulse with read data.
- Sits between the CPU datapath/DMA engine and the memory wrapper; the CPU's ok is the control unit's MemOK.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles mem_en is held per access (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request; a pulse or a level is accepted
cpu_we  in  1  CPU write (1) / read (0)
cpu_half  in  1  CPU halfword access
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ok  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  DW  CPU read data, registered
dma_req  in  1  DMA request
dma_we  in  1  DMA write/read
dma_addr  in  AW  DMA address
dma_wdata  in  DW  DMA write data
dma_ok  out  1  one-cycle completion pulse to DMA
dma_rdata  out  DW  DMA read data, registered
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_half  out  1  halfword access
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid on the last mem_en cycle
grant  out  1  current owner: 0=CPU, 1=DMA
busy  out  1  high in ACCESS and DONE

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE; pending bits=0; last_grant=1 (DMA), so the CPU wins the first tie.
  - cnt=0; grant=0.
  - All ok/mem_* outputs=0; rdata registers=0; command registers=0.
- Request capture:
  - Each cycle, if req=1 and the pending bit is 0, set pending and latch {we, half, addr, wdata} into that requester's command register.
  - A req while pending=1 is ignored; the command is not overwritten.
  - The pending bit clears on the edge that raises that requester's ok. A req in that same cycle is captured as a new request.
- FSM:
  - IDLE:
    - No pending → stay in IDLE.
    - One pending → grant it.
    - Both pending → grant the requester != last_grant.
    - On any grant: load grant and cnt=MEM_LAT-1, go to ACCESS.
  - ACCESS:
    - mem_en=1; mem_we/half/addr/wdata are driven from the granted command register.
    - cnt>0 → decrement.
    - cnt==0 → on a read, capture mem_rdata into the granted rdata register; set last_grant=grant; go to DONE.
  - DONE:
    - mem_en=0; the granted ok=1 for exactly this cycle; go to IDLE.
- Latency:
  - req at edge k (arbiter idle) → mem_en high for edges k+1..k+MEM_LAT → ok high in the cycle after the last mem_en cycle.
  - With MEM_LAT=2, cpu_ok goes high 3 cycles after req is sampled.
  - Back-to-back accesses have one IDLE bubble between them.
- Data rules:
  - Writes do not modify rdata.
  - rdata holds its value until the next read completes for that requester.
  - ok is never asserted to the non-granted requester.
- Reset mid-access:
  - mem_en and ok drop immediately and asynchronously.
  - Pending commands are discarded; the requester must re-issue.
- Simultaneous events: if the granted requester issues a new req during ACCESS, it is ignored (pending is still 1).

Optional Feature:
- Macro name: CPU_PRIORITY_EN.
- Defined: fixed priority; when both are pending in IDLE, the CPU is always granted, and last_grant is unused. DMA can be starved by continuous CPU traffic.
- Undefined: round-robin as specified above.

Test Plan:
- Lone CPU read: cpu_req pulse, addr=0x40, mem_rdata=0xDEADBEEF → mem_en high 2 cycles with mem_addr=0x40; cpu_ok pulses 3 cycles after req; cpu_rdata=0xDEADBEEF; dma_ok stays 0.
- Simultaneous requests: cpu_req=dma_req=1 at the same edge after reset → CPU served first, then DMA. A repeated tie → DMA served first (round-robin). With CPU_PRIORITY_EN → CPU served first both times.
- Write: dma_we=1, addr=0x100, wdata=0x12345678 → mem_we=1 with mem_wdata=0x12345678 for 2 cycles; dma_ok pulses; dma_rdata unchanged.
- Request during busy: cpu_req pulse during a DMA ACCESS with addr=0x8 → CPU command is held; CPU is served after DMA DONE+IDLE with mem_addr=0x8. A second cpu_req while pending does not change the addr.
- Reset mid-operation: rst_n=0 in the second ACCESS cycle → mem_en=0 and busy=0 immediately; after release, no ok pulse appears without a new req.
- Halfword store: cpu_half=1, cpu_we=1 → mem_half=1 throughout ACCESS; mem_half=0 in IDLE.
